clock_ctrl: RTL

Programmable clock generator for the CPU core. It derives a divided clock `clk_out` from the master `clk` and offers free-run, stop, single-step and N-cycle burst modes. It replaces the fixed-rate, free-running generator with stop request. `clk_out` always parks HIGH, so control bits are written on the first falling edge after a restart. It also provides edge strobes and a cycle counter for the debug panel and trace logic.

---
 rtl/clock_ctrl_if.sv | 29 ++
 rtl/clock_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/clock_ctrl_if.sv
// Command and status bundle between a clock_ctrl instance and whoever drives it
// (debug panel, trace logic). The generator itself uses the slave view.
interface clock_ctrl_if #(
    parameter int DIV_W   = 8,
    parameter int BURST_W = 16,
    parameter int CNT_W   = 32
);
    logic [DIV_W-1:0]   div;
    logic               start;
    logic               stop_req;
    logic               step;
    logic               burst_go;
    logic [BURST_W-1:0] burst_len;
    logic               clk_out;
    logic               rise_stb;
    logic               fall_stb;
    logic               running;
    logic [CNT_W-1:0]   cycle_cnt;

    modport master (
        output div, start, stop_req, step, burst_go, burst_len,
        input  clk_out, rise_stb, fall_stb, running, cycle_cnt
    );

    modport slave (
        input  div, start, stop_req, step, burst_go, burst_len,
        output clk_out, rise_stb, fall_stb, running, cycle_cnt
    );
endinterface

// File: rtl/clock_ctrl.sv
// Programmable CPU clock generator: divided clk_out with free-run, stop,
// single-step and N-cycle burst modes, plus edge strobes and a cycle counter.
module clock_ctrl #(
    parameter int DIV_W     = 8,
    parameter int BURST_W   = 16,
    parameter int CNT_W     = 32,
    parameter bit RESET_RUN = 1'b1
) (
    input  logic        clk,
    input  logic        arst,
    clock_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_STEP,
        ST_BURST
    } state_e;

    localparam state_e RESET_STATE = RESET_RUN ? ST_RUN : ST_STOP;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               clk_out_q, clk_out_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               running_q, running_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            div_q     <= bus.div;
            rem_q     <= '0;
            clk_out_q <= 1'b1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            running_q <= RESET_RUN;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            rem_q     <= rem_d;
            clk_out_q <= clk_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            running_q <= running_d;
            cycle_q   <= cycle_d;
        end
    end

    // clk_out only parks high: a stop request is honoured at the falling
    // decision point, never in the middle of a low phase.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        rem_d     = rem_q;
        clk_out_d = clk_out_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        cycle_d   = cycle_q;

        if (state_q == ST_STOP) begin
            cnt_d     = '0;
            clk_out_d = 1'b1;
            if (bus.start) begin
                state_d = ST_RUN;
                div_d   = bus.div;
            end else if (bus.burst_go && (bus.burst_len != '0)) begin
                state_d = ST_BURST;
                rem_d   = bus.burst_len;
                div_d   = bus.div;
            end else if (bus.step) begin
                state_d = ST_STEP;
                div_d   = bus.div;
            end
        end else if (cnt_q == div_q) begin
            cnt_d = '0;
            if (!clk_out_q) begin
                clk_out_d = 1'b1;
                rise_d    = 1'b1;
                cycle_d   = cycle_q + CNT_W'(1);
                div_d     = bus.div;
                if ((state_q == ST_STEP) ||
                    ((state_q == ST_BURST) && (rem_q == '0))) begin
                    state_d = ST_STOP;
                end
            end else if (bus.stop_req) begin
                state_d = ST_STOP;
            end else begin
                clk_out_d = 1'b0;
                fall_d    = 1'b1;
                if (state_q == ST_BURST) begin
                    rem_d = rem_q - BURST_W'(1);
                end
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        running_d = (state_d != ST_STOP);
    end

    assign bus.clk_out   = clk_out_q;
    assign bus.rise_stb  = rise_q;
    assign bus.fall_stb  = fall_q;
    assign bus.running   = running_q;
    assign bus.cycle_cnt = cycle_q;

endmodule
